// File: rtl/eth_stats_pkg.sv
// Shared types and constants for the Ethernet statistics sampler.
package eth_stats_pkg;

    localparam int unsigned ETH_STATS_RECORD_WORDS = 14;
    localparam int unsigned ETH_STATS_IDX_W        = 4;
    localparam int unsigned ETH_STATS_DATA_W       = 32;
    localparam int unsigned ETH_STATS_CNT_W        = 64;
    localparam int unsigned ETH_STATS_ID_W         = 6;
    localparam int unsigned ETH_STATS_PERIOD_W     = 32;
    localparam int unsigned ETH_STATS_DROP_W       = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } eth_stats_sampler_state_t;

    typedef struct packed {
        logic [ETH_STATS_CNT_W-1:0] timestamp;
        logic [ETH_STATS_CNT_W-1:0] tx_bytes;
        logic [ETH_STATS_CNT_W-1:0] tx_good;
        logic [ETH_STATS_CNT_W-1:0] tx_bad;
        logic [ETH_STATS_CNT_W-1:0] rx_bytes;
        logic [ETH_STATS_CNT_W-1:0] rx_good;
        logic [ETH_STATS_CNT_W-1:0] rx_bad;
    } eth_stats_snap_t;

    // Record word idx: even index = low half, odd index = high half of each 64-bit field.
    function automatic logic [ETH_STATS_DATA_W-1:0] eth_stats_word(
        input eth_stats_snap_t              snap,
        input logic [ETH_STATS_IDX_W-1:0]   idx
    );
        logic [ETH_STATS_CNT_W-1:0] w_sel;
        case (idx[ETH_STATS_IDX_W-1:1])
            3'd0:    w_sel = snap.timestamp;
            3'd1:    w_sel = snap.tx_bytes;
            3'd2:    w_sel = snap.tx_good;
            3'd3:    w_sel = snap.tx_bad;
            3'd4:    w_sel = snap.rx_bytes;
            3'd5:    w_sel = snap.rx_good;
            default: w_sel = snap.rx_bad;
        endcase
        return idx[0] ? w_sel[ETH_STATS_CNT_W-1:ETH_STATS_DATA_W]
                      : w_sel[ETH_STATS_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/eth_stats_trigger.sv
// Sampling trigger: stats_id change detect (period 0) or free-running period counter.
module eth_stats_trigger
    import eth_stats_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          srst,
    input  logic                          enable,
    input  logic [ETH_STATS_PERIOD_W-1:0] sample_period,
    input  logic [ETH_STATS_ID_W-1:0]     stats_id,
    output logic                          trigger_c
);

    logic [ETH_STATS_ID_W-1:0]     r_id_q;
    logic [ETH_STATS_PERIOD_W-1:0] r_cnt;
    logic                          w_periodic;
    logic                          w_period_hit;
    logic                          w_change;

    assign w_periodic   = (sample_period != '0);
    // >= keeps a lowered period from stalling the counter past its new limit.
    assign w_period_hit = (r_cnt >= (sample_period - ETH_STATS_PERIOD_W'(1)));
    assign w_change     = (stats_id != r_id_q);
    assign trigger_c    = ~srst & enable & (w_periodic ? w_period_hit : w_change);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id_q <= '0;
        end else if (srst) begin
            r_id_q <= '0;
        end else begin
            r_id_q <= stats_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (srst) begin
            r_cnt <= '0;
        end else if (w_periodic && enable) begin
            r_cnt <= w_period_hit ? '0 : r_cnt + ETH_STATS_PERIOD_W'(1);
        end
    end

endmodule

// File: rtl/eth_stats_sampler.sv
// Snapshots the traffic counters on each trigger and streams a 14-word record to the stats FIFO.
module eth_stats_sampler
    import eth_stats_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          srst,
    input  logic                          enable,
    input  logic [ETH_STATS_PERIOD_W-1:0] sample_period,
    input  logic [ETH_STATS_CNT_W-1:0]    current_time,
    input  logic [ETH_STATS_ID_W-1:0]     stats_id,
    input  logic [ETH_STATS_CNT_W-1:0]    tx_bytes,
    input  logic [ETH_STATS_CNT_W-1:0]    tx_good,
    input  logic [ETH_STATS_CNT_W-1:0]    tx_bad,
    input  logic [ETH_STATS_CNT_W-1:0]    rx_bytes,
    input  logic [ETH_STATS_CNT_W-1:0]    rx_good,
    input  logic [ETH_STATS_CNT_W-1:0]    rx_bad,
    output logic [ETH_STATS_DATA_W-1:0]   fifo_wdata,
    output logic                          fifo_wlast,
    output logic                          fifo_wvalid,
    input  logic                          fifo_wready,
    output logic [ETH_STATS_DROP_W-1:0]   dropped,
    output logic                          busy
);

    localparam int unsigned C_RECORD_WORDS = ETH_STATS_RECORD_WORDS;
    localparam logic [ETH_STATS_IDX_W-1:0] C_LAST_IDX = ETH_STATS_IDX_W'(C_RECORD_WORDS - 1);

    eth_stats_sampler_state_t      r_state;
    eth_stats_sampler_state_t      w_state_nxt;
    logic [ETH_STATS_IDX_W-1:0]    r_idx;
    logic [ETH_STATS_IDX_W-1:0]    w_idx_nxt;
    logic                          r_pending;
    logic                          w_pending_nxt;
    logic [ETH_STATS_DROP_W-1:0]   r_dropped;
    logic [ETH_STATS_DROP_W-1:0]   w_dropped_nxt;
    logic                          w_capture;

    eth_stats_snap_t               r_snap;
    eth_stats_snap_t               w_snap_in;
    eth_stats_snap_t               w_snap_nxt;

    logic [ETH_STATS_DATA_W-1:0]   r_wdata;
    logic                          r_wlast;
    logic                          r_wvalid;
    logic                          r_busy;
    logic [ETH_STATS_DATA_W-1:0]   w_wdata_nxt;
    logic                          w_wlast_nxt;
    logic                          w_wvalid_nxt;
    logic                          w_busy_nxt;

    logic                          w_trigger;
    logic                          w_hs;

    eth_stats_trigger u_trigger (
        .clk           (clk),
        .rst_n         (rst_n),
        .srst          (srst),
        .enable        (enable),
        .sample_period (sample_period),
        .stats_id      (stats_id),
        .trigger_c     (w_trigger)
    );

    assign w_hs = r_wvalid & fifo_wready;

    always_comb begin
        w_snap_in           = '0;
        w_snap_in.timestamp = current_time;
        w_snap_in.tx_bytes  = tx_bytes;
        w_snap_in.tx_good   = tx_good;
        w_snap_in.tx_bad    = tx_bad;
        w_snap_in.rx_bytes  = rx_bytes;
        w_snap_in.rx_good   = rx_good;
        w_snap_in.rx_bad    = rx_bad;
    end

    // Next-state logic for the record emitter.
    always_comb begin
        w_state_nxt   = r_state;
        w_idx_nxt     = r_idx;
        w_pending_nxt = r_pending;
        w_dropped_nxt = r_dropped;
        w_capture     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_trigger) begin
                    w_capture   = 1'b1;
                    w_idx_nxt   = '0;
                    w_state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (w_hs && (r_idx == C_LAST_IDX)) begin
                    // A trigger on the final handshake is folded into the next record, not dropped.
                    if (r_pending || w_trigger) begin
                        w_capture     = 1'b1;
                        w_idx_nxt     = '0;
                        w_pending_nxt = r_pending & w_trigger;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = IDLE;
                    end
                end else begin
                    if (w_hs) begin
                        w_idx_nxt = r_idx + ETH_STATS_IDX_W'(1);
                    end
                    if (w_trigger) begin
                        if (!r_pending) begin
                            w_pending_nxt = 1'b1;
                        end else if (r_dropped != '1) begin
                            w_dropped_nxt = r_dropped + ETH_STATS_DROP_W'(1);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = '0;
            end
        endcase

        if (srst) begin
            w_state_nxt   = IDLE;
            w_idx_nxt     = '0;
            w_pending_nxt = 1'b0;
            w_dropped_nxt = '0;
            w_capture     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_idx     <= '0;
            r_pending <= 1'b0;
            r_dropped <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_idx     <= w_idx_nxt;
            r_pending <= w_pending_nxt;
            r_dropped <= w_dropped_nxt;
        end
    end

    // Output word is precomputed from next index/snapshot so the stream ports are registered.
    always_comb begin
        w_snap_nxt   = w_capture ? w_snap_in : r_snap;
        w_wvalid_nxt = (w_state_nxt == EMIT);
        w_wlast_nxt  = w_wvalid_nxt & (w_idx_nxt == C_LAST_IDX);
        w_wdata_nxt  = w_wvalid_nxt ? eth_stats_word(w_snap_nxt, w_idx_nxt) : '0;
        w_busy_nxt   = w_wvalid_nxt | w_pending_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap   <= '0;
            r_wdata  <= '0;
            r_wlast  <= 1'b0;
            r_wvalid <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_snap   <= w_snap_nxt;
            r_wdata  <= w_wdata_nxt;
            r_wlast  <= w_wlast_nxt;
            r_wvalid <= w_wvalid_nxt;
            r_busy   <= w_busy_nxt;
        end
    end

    assign fifo_wdata  = r_wdata;
    assign fifo_wlast  = r_wlast;
    assign fifo_wvalid = r_wvalid;
    assign dropped     = r_dropped;
    assign busy        = r_busy;

endmodule

// File: tb/tb_eth_stats_sampler.sv
// Directed bench for eth_stats_sampler: on-change, periodic, backpressure, drops and resets.
module tb_eth_stats_sampler;

    logic        clk;
    logic        rst_n;
    logic        srst;
    logic        enable;
    logic [31:0] sample_period;
    logic [63:0] current_time;
    logic [5:0]  stats_id;
    logic [63:0] tx_bytes, tx_good, tx_bad, rx_bytes, rx_good, rx_bad;
    logic [31:0] fifo_wdata;
    logic        fifo_wlast;
    logic        fifo_wvalid;
    logic        fifo_wready;
    logic [31:0] dropped;
    logic        busy;

    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] exp_w [14];
    logic [15:0] bp_pat = 16'b0110_1001_1100_0101;

    eth_stats_sampler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .srst          (srst),
        .enable        (enable),
        .sample_period (sample_period),
        .current_time  (current_time),
        .stats_id      (stats_id),
        .tx_bytes      (tx_bytes),
        .tx_good       (tx_good),
        .tx_bad        (tx_bad),
        .rx_bytes      (rx_bytes),
        .rx_good       (rx_good),
        .rx_bad        (rx_bad),
        .fifo_wdata    (fifo_wdata),
        .fifo_wlast    (fifo_wlast),
        .fifo_wvalid   (fifo_wvalid),
        .fifo_wready   (fifo_wready),
        .dropped       (dropped),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Expected record built from the current input values, in stream order.
    task automatic set_exp();
        logic [63:0] v [7];
        v[0] = current_time; v[1] = tx_bytes; v[2] = tx_good; v[3] = tx_bad;
        v[4] = rx_bytes;     v[5] = rx_good;  v[6] = rx_bad;
        for (int k = 0; k < 7; k++) begin
            exp_w[2*k]   = v[k][31:0];
            exp_w[2*k+1] = v[k][63:32];
        end
    endtask

    task automatic set_vals(input logic [31:0] s);
        current_time = {s, ~s};
        tx_bytes     = {s + 32'd1, 32'h1000_0001};
        tx_good      = {s + 32'd2, 32'h2000_0002};
        tx_bad       = {s + 32'd3, 32'h3000_0003};
        rx_bytes     = {s + 32'd4, 32'h4000_0004};
        rx_good      = {s + 32'd5, 32'h5000_0005};
        rx_bad       = {s + 32'd6, 32'h6000_0006};
    endtask

    // Consume one record starting at the next negedge; valid must stay high until word 13.
    task automatic collect_record(input string tag, input bit use_bp);
        int          n       = 0;
        int          cyc     = 0;
        bit          stalled = 1'b0;
        logic [31:0] held    = '0;
        while (n < 14 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            chk({tag, "/valid"}, 64'(fifo_wvalid), 64'd1);
            if (stalled) chk({tag, "/stall_data"}, 64'(fifo_wdata), 64'(held));
            fifo_wready = use_bp ? bp_pat[cyc % 16] : 1'b1;
            if (fifo_wvalid && fifo_wready) begin
                chk($sformatf("%s/word%0d", tag, n), 64'(fifo_wdata), 64'(exp_w[n]));
                chk($sformatf("%s/last%0d", tag, n), 64'(fifo_wlast), 64'(n == 13));
                n++;
                stalled = 1'b0;
            end else begin
                stalled = fifo_wvalid;
                held    = fifo_wdata;
            end
        end
        chk({tag, "/handshakes"}, 64'(n), 64'd14);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int prev, starts, last_k;
        rst_n = 1'b0; srst = 1'b0; enable = 1'b0; sample_period = '0;
        stats_id = '0; fifo_wready = 1'b0;
        set_vals(32'h0);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst/wvalid",  64'(fifo_wvalid), 64'd0);
        chk("rst/wlast",   64'(fifo_wlast),  64'd0);
        chk("rst/wdata",   64'(fifo_wdata),  64'd0);
        chk("rst/dropped", 64'(dropped),     64'd0);
        chk("rst/busy",    64'(busy),        64'd0);
        rst_n = 1'b1; enable = 1'b1; fifo_wready = 1'b1;
        repeat (3) @(negedge clk);

        // On-change record: stats_id 0 -> 1
        chk("chg/idle", 64'(fifo_wvalid), 64'd0);
        set_vals(32'h0000_0001);
        current_time = 64'h100;
        tx_bytes     = 64'h1_0000_0040;
        stats_id     = 6'd1;
        set_exp();
        collect_record("chg", 1'b0);
        @(negedge clk);
        chk("chg/end_valid", 64'(fifo_wvalid), 64'd0);
        chk("chg/end_busy",  64'(busy),        64'd0);

        // Periodic mode, period 20: 5 records in 100 cycles
        srst = 1'b1; enable = 1'b0;
        @(negedge clk);
        srst = 1'b0; sample_period = 32'd20; enable = 1'b1;
        prev = 0; starts = 0; last_k = 0;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (fifo_wvalid && prev == 0) begin
                if (starts == 0) chk("per/first_start", 64'(k), 64'd20);
                else             chk("per/spacing", 64'(k - last_k), 64'd20);
                last_k = k;
                starts++;
            end
            prev = int'(fifo_wvalid);
        end
        chk("per/records", 64'(starts), 64'd5);
        enable = 1'b0;
        repeat (20) @(negedge clk);
        chk("per/idle_busy", 64'(busy), 64'd0);
        sample_period = '0;
        enable = 1'b1;
        @(negedge clk);

        // Backpressure during a record
        set_vals(32'h00C0_0000);
        stats_id = 6'd2;
        set_exp();
        collect_record("bp", 1'b1);
        @(negedge clk);
        chk("bp/end_valid", 64'(fifo_wvalid), 64'd0);

        // Drops: 4 triggers while stalled -> 1 record, 1 pending, 2 dropped
        fifo_wready = 1'b0;
        set_vals(32'h0A00_0000);
        stats_id = 6'd3;
        set_exp();
        @(negedge clk);
        set_vals(32'h0B00_0000);
        stats_id = 6'd4;
        @(negedge clk);
        stats_id = 6'd5;
        @(negedge clk);
        stats_id = 6'd6;
        @(negedge clk);
        chk("drop/dropped", 64'(dropped),     64'd2);
        chk("drop/busy",    64'(busy),        64'd1);
        chk("drop/held",    64'(fifo_wdata),  64'(exp_w[0]));
        collect_record("drop/rec1", 1'b0);
        set_exp();
        collect_record("drop/rec2", 1'b0);
        @(negedge clk);
        chk("drop/end_valid",   64'(fifo_wvalid), 64'd0);
        chk("drop/end_busy",    64'(busy),        64'd0);
        chk("drop/end_dropped", 64'(dropped),     64'd2);

        // Soft reset at word 6; id_q clears so the held stats_id retriggers at once
        set_vals(32'h0D00_0000);
        stats_id = 6'd7;
        set_exp();
        for (int i = 0; i < 7; i++) @(negedge clk);
        chk("srst/word6", 64'(fifo_wdata), 64'(exp_w[6]));
        srst = 1'b1;
        @(negedge clk);
        srst = 1'b0;
        chk("srst/wvalid",  64'(fifo_wvalid), 64'd0);
        chk("srst/wdata",   64'(fifo_wdata),  64'd0);
        chk("srst/dropped", 64'(dropped),     64'd0);
        chk("srst/busy",    64'(busy),        64'd0);
        collect_record("srst/rec", 1'b0);
        @(negedge clk);
        chk("srst/end_valid", 64'(fifo_wvalid), 64'd0);

        // Async reset mid-record, no clock edge between assert and check
        fifo_wready = 1'b0;
        stats_id = 6'd8;
        @(negedge clk);
        stats_id = 6'd9;
        @(negedge clk);
        stats_id = 6'd10;
        @(negedge clk);
        chk("arst/pre_dropped", 64'(dropped),     64'd1);
        chk("arst/pre_valid",   64'(fifo_wvalid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst/wvalid",  64'(fifo_wvalid), 64'd0);
        chk("arst/wdata",   64'(fifo_wdata),  64'd0);
        chk("arst/wlast",   64'(fifo_wlast),  64'd0);
        chk("arst/dropped", 64'(dropped),     64'd0);
        chk("arst/busy",    64'(busy),        64'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst/after", 64'(fifo_wvalid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
